pipe_if_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register. It feeds the ID-stage control/decode logic.

---
 rtl/pipe_if_stage.sv | 102 ++++++++++
 tb/tb_pipe_if_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with IF/ID register: PC, redirect handling, stall/flush counters.
// A taken redirect squashes the fetched word into a bubble since there is no delay slot.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MIO_ready,
  input  logic             shouldStall,
  input  logic             shouldJumpOrBranch,
  input  logic             jump,
  input  logic             jumpRs,
  input  logic [31:0]      id_rsData,
  input  logic             cp0_redirect,
  input  logic [31:0]      cp0_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      id_instruction,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc_plus4,
  output logic             id_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_idPc;
  logic [31:0]      r_idPcPlus4;
  logic             r_valid;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  logic [31:0] w_pcPlus4;
  logic [15:0] w_imm;
  logic [31:0] w_branchTarget;
  logic [31:0] w_jumpTarget;
  logic [31:0] w_jrTarget;
  logic [31:0] w_cp0Target;
  logic [31:0] w_redirectTarget;

  // All targets derive from the instruction currently sitting in IF/ID.
  assign w_pcPlus4      = r_pc + 32'd4;
  assign w_imm          = r_instr[15:0];
  assign w_branchTarget = r_idPcPlus4 + {{14{w_imm[15]}}, w_imm, 2'b00};
  assign w_jumpTarget   = {r_idPcPlus4[31:28], r_instr[25:0], 2'b00};
  assign w_jrTarget     = {id_rsData[31:2], 2'b00};
  assign w_cp0Target    = {cp0_target[31:2], 2'b00};

  always_comb begin
    w_redirectTarget = w_branchTarget;
    if (jumpRs)
      w_redirectTarget = w_jrTarget;
    else if (jump)
      w_redirectTarget = w_jumpTarget;
  end

  // CP0 outranks the hazard stall; the ID redirect only acts on an unstalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_instr     <= 32'h0;
      r_idPc      <= 32'h0;
      r_idPcPlus4 <= 32'h0;
      r_valid     <= 1'b0;
      r_stallCnt  <= '0;
      r_flushCnt  <= '0;
    end else if (MIO_ready) begin
      if (cp0_redirect) begin
        r_pc       <= w_cp0Target;
        r_instr    <= 32'h0;
        r_valid    <= 1'b0;
        r_flushCnt <= r_flushCnt + CNT_ONE;
      end else if (shouldStall) begin
        r_stallCnt <= r_stallCnt + CNT_ONE;
      end else if (shouldJumpOrBranch) begin
        r_pc       <= w_redirectTarget;
        r_instr    <= 32'h0;
        r_valid    <= 1'b0;
        r_flushCnt <= r_flushCnt + CNT_ONE;
      end else begin
        r_pc        <= w_pcPlus4;
        r_instr     <= imem_rdata;
        r_idPc      <= r_pc;
        r_idPcPlus4 <= w_pcPlus4;
        r_valid     <= 1'b1;
      end
    end
  end

  assign imem_addr      = r_pc;
  assign id_instruction = r_instr;
  assign id_pc          = r_idPc;
  assign id_pc_plus4    = r_idPcPlus4;
  assign id_valid       = r_valid;
  assign stall_count    = r_stallCnt;
  assign flush_count    = r_flushCnt;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Self-checking bench for pipe_if_stage: directed scenarios then randomized traffic
// compared against a behavioural model of the fetch stage.
module tb_pipe_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MIO_ready;
  logic        shouldStall;
  logic        shouldJumpOrBranch;
  logic        jump;
  logic        jumpRs;
  logic [31:0] id_rsData;
  logic        cp0_redirect;
  logic [31:0] cp0_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Model state
  logic [31:0] mPc, mInstr, mIdPc, mIdPc4, mStall, mFlush;
  logic        mValid;

  pipe_if_stage #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .MIO_ready(MIO_ready), .shouldStall(shouldStall),
    .shouldJumpOrBranch(shouldJumpOrBranch), .jump(jump), .jumpRs(jumpRs),
    .id_rsData(id_rsData), .cp0_redirect(cp0_redirect), .cp0_target(cp0_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .id_instruction(id_instruction),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents, with a few fixed words the directed scenarios rely on.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0010: return 32'h1000_FFFC;
      32'h8000_0020: return 32'h0800_0040;
      default:       return (addr * 32'h0100_0193) ^ 32'h3C01_0000;
    endcase
  endfunction

  always_comb imem_rdata = memWord(imem_addr);

  // Behavioural model of one clock edge, using the inputs present at that edge.
  task automatic modelEdge();
    logic signed [31:0] offset;
    logic [31:0]        target;
    if (rst) begin
      mPc = 32'h0; mInstr = 32'h0; mIdPc = 32'h0; mIdPc4 = 32'h0;
      mValid = 1'b0; mStall = 32'h0; mFlush = 32'h0;
    end else if (!MIO_ready) begin
      // frozen
    end else if (cp0_redirect) begin
      mPc = cp0_target & ~32'd3;
      mInstr = 32'h0; mValid = 1'b0; mFlush = mFlush + 1;
    end else if (shouldStall) begin
      mStall = mStall + 1;
    end else if (shouldJumpOrBranch) begin
      if (jumpRs)
        target = id_rsData & ~32'd3;
      else if (jump)
        target = (mIdPc4 & 32'hF000_0000) | ((mInstr & 32'h03FF_FFFF) * 4);
      else begin
        offset = 32'(signed'(mInstr[15:0]));
        target = mIdPc4 + 32'(offset * 4);
      end
      mPc = target;
      mInstr = 32'h0; mValid = 1'b0; mFlush = mFlush + 1;
    end else begin
      mInstr = memWord(mPc); mIdPc = mPc; mIdPc4 = mPc + 4;
      mValid = 1'b1; mPc = mPc + 4;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAgainstModel();
    checkOutput("imem_addr", imem_addr, mPc);
    checkOutput("id_instruction", id_instruction, mInstr);
    checkOutput("id_pc", id_pc, mIdPc);
    checkOutput("id_pc_plus4", id_pc_plus4, mIdPc4);
    checkOutput("id_valid", {31'h0, id_valid}, {31'h0, mValid});
    checkOutput("stall_count", stall_count, mStall);
    checkOutput("flush_count", flush_count, mFlush);
  endtask

  // One clock: edge, model update, sample 1 time unit later.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkAgainstModel();
  endtask

  task automatic idleInputs();
    rst = 1'b0; MIO_ready = 1'b1; shouldStall = 1'b0; shouldJumpOrBranch = 1'b0;
    jump = 1'b0; jumpRs = 1'b0; id_rsData = 32'h0; cp0_redirect = 1'b0; cp0_target = 32'h0;
  endtask

  initial begin
    idleInputs();
    mPc = 32'h0; mInstr = 32'h0; mIdPc = 32'h0; mIdPc4 = 32'h0;
    mValid = 1'b0; mStall = 32'h0; mFlush = 32'h0;

    // Reset for two cycles
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("reset_pc", imem_addr, 32'h0);
    checkOutput("reset_valid", {31'h0, id_valid}, 32'h0);

    // First fetch
    rst = 1'b0;
    applyStimulus();
    checkOutput("first_instr", id_instruction, 32'h2008_0005);
    checkOutput("first_pc4", id_pc_plus4, 32'h4);
    checkOutput("first_next_pc", imem_addr, 32'h4);

    // Reach pc=8, then stall three cycles
    applyStimulus();
    checkOutput("pc_before_stall", imem_addr, 32'h8);
    shouldStall = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("stall_pc_held", imem_addr, 32'h8);
    checkOutput("stall_count_3", stall_count, 32'd3);
    shouldStall = 1'b0;
    applyStimulus();
    checkOutput("resume_id_pc", id_pc, 32'h8);

    // Fetch 0xC and 0x10 (the beq), then take the branch back to 0x04
    applyStimulus();
    applyStimulus();
    checkOutput("beq_in_id", id_pc, 32'h10);
    shouldJumpOrBranch = 1'b1;
    applyStimulus();
    shouldJumpOrBranch = 1'b0;
    checkOutput("beq_target", imem_addr, 32'h4);
    checkOutput("beq_bubble", id_instruction, 32'h0);
    checkOutput("beq_flush", flush_count, 32'd1);

    // CP0 redirect to 0x8000_0020, fetch the j there, then take it
    cp0_redirect = 1'b1; cp0_target = 32'h8000_0020;
    applyStimulus();
    cp0_redirect = 1'b0;
    applyStimulus();
    checkOutput("j_in_id", id_pc, 32'h8000_0020);
    shouldJumpOrBranch = 1'b1; jump = 1'b1;
    applyStimulus();
    checkOutput("j_target", imem_addr, 32'h8000_0100);

    // jr with unaligned register value
    jump = 1'b0; jumpRs = 1'b1; id_rsData = 32'h0000_1237;
    applyStimulus();
    checkOutput("jr_target", imem_addr, 32'h0000_1234);

    // Memory not ready during a redirect request: nothing moves until ready returns
    id_rsData = 32'h0000_2000; MIO_ready = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("mio_freeze_pc", imem_addr, 32'h0000_1234);
    MIO_ready = 1'b1;
    applyStimulus();
    checkOutput("mio_release_pc", imem_addr, 32'h0000_2000);
    shouldJumpOrBranch = 1'b0; jumpRs = 1'b0;
    applyStimulus();

    // CP0 redirect wins over a concurrent stall
    shouldStall = 1'b1; cp0_redirect = 1'b1; cp0_target = 32'h0000_0180;
    applyStimulus();
    checkOutput("cp0_over_stall_pc", imem_addr, 32'h180);
    checkOutput("cp0_over_stall_valid", {31'h0, id_valid}, 32'h0);
    cp0_redirect = 1'b0;
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    checkOutput("midstall_reset_pc", imem_addr, 32'h0);
    checkOutput("midstall_reset_stall", stall_count, 32'h0);
    checkOutput("midstall_reset_flush", flush_count, 32'h0);
    idleInputs();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 99) < 2);
      MIO_ready    = ($urandom_range(0, 99) < 85);
      shouldStall  = ($urandom_range(0, 99) < 20);
      shouldJumpOrBranch = !shouldStall && ($urandom_range(0, 99) < 25);
      jump         = $urandom_range(0, 1) == 1;
      jumpRs       = ($urandom_range(0, 99) < 30);
      id_rsData    = $urandom;
      cp0_redirect = ($urandom_range(0, 99) < 5);
      cp0_target   = $urandom;
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
